bcd2_counter_scan: RTL
======================

Name: bcd2_counter_scan

Overview:
Two-digit BCD up/down counter with its own tick divider and display-scan select generator. It drives the seven-segment scan stage directly: digit1/digit0 feed that stage's tens/ones digit inputs, and scan_sel feeds its 1-bit digit-select input. It sits between board I/O (switches/buttons, already debounced) and the SSD path.

Parameters:
TICK_DIV, 100000000, clk cycles per count tick (1 Hz at 100 MHz); legal range 2..2^27.
SCAN_BITS, 17, width of the free-running scan counter; its MSB is scan_sel (~763 Hz at 100 MHz); legal range 2..24.

Ports:
clk  input  1  system clock.
rst_n  input  1  synchronous reset, active-low.
en  input  1  count enable; 0 = pause.
up_dn  input  1  1 = count up, 0 = count down.
load  input  1  load digits this cycle (level, sampled every clk).
load_d1  input  4  tens value to load.
load_d0  input  4  ones value to load.
digit1  output  4  tens BCD digit (registered).
digit0  output  4  ones BCD digit (registered).
scan_sel  output  1  digit select for the scan stage (MSB of scan counter).
tick  output  1  one-cycle pulse at each count step.
wrap  output  1  one-cycle pulse, coincident with the step that wraps 99->00 or 00->99.

Behaviour:
- Reset: synchronous, active-low. It is sampled on the clk rising edge; it overrides every other input. All registers clear to 0: digit1=0, digit0=0, tick=0, wrap=0, scan counter=0 (scan_sel=0), divider=0.
- Divider: counts 0..TICK_DIV-1 only while en=1 and load=0.
  - When the divider reaches TICK_DIV-1 with en=1, it returns to 0 next cycle and tick is asserted for that one cycle (registered, 1-cycle latency).
  - en=0 freezes the divider value, so pause preserves phase.
  - load=1 clears the divider to 0.
- Count step: applied in the same edge that registers tick=1.
  - Up: digit0 +1. At digit0=9 it goes to 0 and digit1 increments. At 99 the counter goes to 00 with wrap=1.
  - Down: digit0 -1. At digit0=0 it goes to 9 and digit1 decrements. At 00 the counter goes to 99 with wrap=1.
  - up_dn is sampled at the step edge. Changing it mid-period takes effect at the next step.
- Load: load=1 writes the digits at the next edge.
  - Any load value >9 is clamped to 9 per digit.
  - Load has priority over a coincident step; the step is dropped, and tick and wrap stay 0 that cycle.
  - Load works regardless of en.
- Scan counter: free-running SCAN_BITS-bit counter that increments every clk and wraps naturally. It is unaffected by en and load; only rst_n clears it. scan_sel = counter[SCAN_BITS-1].
- Invariant: digit1 and digit0 are always in 0..9. No non-BCD state is reachable.
- Reset mid-period: the divider restarts from 0. The first tick after reset release occurs exactly TICK_DIV cycles after the first cycle with en=1.
- tick and wrap are never asserted while rst_n=0 or load=1.

Decomposition:
- Shared package bcd_pkg: BCD_MAX=4'd9, BCD_MIN=4'd0, a BCD digit typedef (4-bit), and a clamp helper function.
- Sub-module bcd_digit: one BCD digit with inputs step, up_dn, load, load_val and outputs q and a borrow/carry-out. It is instantiated twice, with the ones digit's carry-out gating the tens digit's step.
- Divider and scan counter stay in the top module.

Test Plan:
- Reset and scan (TICK_DIV=4, SCAN_BITS=3): hold rst_n=0 for 3 clk, then release with en=0 -> digits 00, tick=0, wrap=0. scan_sel is 0 for 4 clk, then 1 for 4 clk, repeating; digits stay 00.
- Up count with wrap: load 9,8, then en=1, up_dn=1 -> tick every 4th clk. Sequence 98, 99, 00; wrap=1 exactly on the 99->00 edge; then 01.
- Down count with borrow: load 1,0, then en=1, up_dn=0 -> 09, 08 ... 00, 99 with wrap=1 on the 00->99 edge. The 10->09 step shows digit1 decrementing in the same cycle as digit0 goes to 9.
- Pause and load priority: run up from 00, drop en=0 for 10 clk -> digits and divider hold; the next tick arrives after exactly the remaining cycles. Then assert load=1 with load_d1=4'hC, load_d0=4'h3 on the cycle the divider is at 3 -> digits 93, tick=0, wrap=0; the next tick comes 4 clk after load drops.
- Reset mid-operation: counting at 57 with the divider at 2, pull rst_n=0 for one clk -> next cycle digits 00, scan_sel 0, divider 0. After release, the first tick comes 4 clk later and the digits go to 01.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the two-digit counter.
// Provides the 4-bit BCD digit type, the legal digit bounds and a
// clamp helper that maps any 4-bit value above 9 onto 9.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Load values come straight from switches, so 10..15 must be folded
  // back into the legal range before they reach a digit register.
  function automatic bcd_t clamp_bcd(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : bcd_t'(v);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0..9) with up/down stepping and parallel load.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   step       : advance the digit by one in the direction of up_dn
//   up_dn      : 1 = increment, 0 = decrement
//   load       : write clamp(load_val) at the next edge (beats step)
//   load_val   : raw value to load, clamped to 9
//   q          : registered digit value
//   carry      : combinational carry/borrow-out, high when this step
//                wraps the digit (9->0 going up, 0->9 going down)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
  output bcd_t       q,
  output logic       carry
);

  // Carry is only meaningful together with step so that it can be fed
  // directly into the next digit's step input.
  assign carry = step && !load && (up_dn ? (q == BCD_MAX) : (q == BCD_MIN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= clamp_bcd(load_val);
    end else if (step) begin
      if (up_dn) begin
        q <= (q == BCD_MAX) ? BCD_MIN : bcd_t'(q + 4'd1);
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : bcd_t'(q - 4'd1);
      end
    end
  end

endmodule

// File: rtl/bcd2_counter_scan.sv
// Two-digit BCD up/down counter with a tick divider and a free-running
// scan counter that drives the seven-segment digit select.
// Ports:
//   clk, rst_n       : clock and synchronous active-low reset
//   en               : count enable (0 pauses, divider phase is kept)
//   up_dn            : 1 = count up, 0 = count down
//   load             : load digits this cycle (clears divider, drops step)
//   load_d1, load_d0 : tens / ones values to load (clamped to 9)
//   digit1, digit0   : registered tens / ones BCD digits
//   scan_sel         : MSB of the scan counter, digit select for the SSD
//   tick             : one-cycle pulse on every count step
//   wrap             : one-cycle pulse on the 99->00 / 00->99 step
module bcd2_counter_scan
  import bcd_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int SCAN_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_d1,
  input  logic [3:0] load_d0,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       scan_sel,
  output logic       tick,
  output logic       wrap
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]     div;
  logic [SCAN_BITS-1:0] scan;
  logic                 step;
  logic                 carry0;
  logic                 carry1;
  bcd_t                 q1;
  bcd_t                 q0;

  // A step happens on the edge where the divider leaves its last value;
  // load suppresses it entirely so a coincident load always wins.
  assign step = en && !load && (div == DIV_LAST);

  // Divider: runs only while enabled and not loading, holds on pause,
  // and restarts from 0 on load so the next period is a full one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= carry1;
      if (load) begin
        div <= '0;
      end else if (en) begin
        div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      end
    end
  end

  // Scan counter ignores en and load so the display keeps refreshing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan <= '0;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  assign scan_sel = scan[SCAN_BITS-1];

  // The ones digit's carry/borrow-out becomes the tens digit's step; the
  // tens carry-out therefore marks a full two-digit wrap.
  bcd_digit u_ones (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_d0),
    .q        (q0),
    .carry    (carry0)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (carry0),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_d1),
    .q        (q1),
    .carry    (carry1)
  );

  assign digit1 = q1;
  assign digit0 = q0;

endmodule
